uart_rx8: RTL and testbench
===========================

# uart_rx8

Standalone 8N1 UART receiver with 16x oversampling, start-bit validation and framing-error detection. It is the receiving end of the 8-bit transmitter used in the board-level UART link: it reconstructs bytes from a serial line driven by a peer transmitter on another board or device. It sits between the input pin and the byte-level consumer logic. Its status interface matches the rx side of the existing UART pair, so the two are interchangeable.

## Interface

Parameters:
- CLOCK_RATE, 12000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- OVERSAMPLE, 16: ticks per bit period; must be 16.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rxEn  in  1  receiver enable. Low forces IDLE and aborts any frame in progress.
- rxIn  in  1  asynchronous serial line; idle level is high.
- rxBusy  out  1  high while a frame is in progress (any state except IDLE).
- rxDone  out  1  one-cycle pulse when a valid byte has been latched into rxOut.
- rxErr  out  1  one-cycle pulse on a framing error (stop bit sampled low).
- rxOut  out  8  last valid received byte; held until the next valid byte.

## Operation

- **Synchronizer:** rxIn passes through a 2-flop synchronizer. All references below to "line" mean the synchronized value.
- **Prescaler:** DIV = CLOCK_RATE / (BAUD_RATE*16), using truncating integer division (78 at the defaults).
  - A tick is a one-cycle pulse every DIV cycles.
  - A 4-bit tick counter (0..15) counts ticks within a bit.
  - Both the prescaler and the tick counter are cleared on the start-edge cycle.
- **States:**
  - IDLE: waits for the line to go low while rxEn is high, then goes to START.
  - START: at tick 9, evaluates the start-bit sample. Low goes to DATA with bit index 0. High is a false start: return to IDLE with no pulse.
  - DATA: after each bit, the tick counter wraps 15→0. At tick 9 of each bit the sample is shifted in LSB-first. After bit index 7, go to STOP.
  - STOP: at tick 9, a high sample loads the shift register into rxOut, pulses rxDone and goes to IDLE. A low sample pulses rxErr, leaves rxOut unchanged and goes to BREAK.
  - BREAK: waits for the line to be high, then goes to IDLE. This prevents a held-low line from re-triggering reception.
- **Sample value:** see Configuration. Samples are taken at ticks 7, 8 and 9 of each bit.
- **rxEn low in any state:** next state is IDLE, the prescaler is cleared, and there is no rxDone or rxErr.
- **Reset values:** state IDLE; rxBusy 0, rxDone 0, rxErr 0; rxOut 8'h00; shift register 0; synchronizer flops 1.
- **Precedence:** rst has priority over rxEn; rxEn has priority over line events.
- **Mutual exclusion:** rxDone and rxErr are never high in the same cycle.

## Timing

- Let E be the cycle in which IDLE sees the line low with rxEn high. E is 2–3 cycles after the raw pin falls.
- rxBusy rises at E+1.
- rxDone or rxErr is high exactly at cycle E + 153*DIV, for one cycle. At the defaults this is E+11934.
- rxOut changes in the same cycle that rxDone is asserted.
- rxBusy falls in the cycle after the pulse (STOP→IDLE).
  - Exception: after an error, rxBusy stays high through BREAK.
- **Back-to-back frames:** a start edge arriving ½ bit after the stop-bit decision is accepted, so zero idle bits between frames are supported.
- **False start:** rxBusy falls at E + 9*DIV + 1.
- rxEn falling mid-frame clears rxBusy on the next cycle.

## Configuration

- **UART_RX_MAJORITY_EN defined:** each bit value is the 2-of-3 majority of the samples at ticks 7, 8 and 9.
- **UART_RX_MAJORITY_EN undefined:** the bit value is the tick-8 sample only, latched and evaluated at tick 9.
- Latency is identical in both builds.

## Test plan

- Reset, then send 8'b10001010 at 9600 baud with a valid stop bit → rxDone pulses once at E+11934; rxOut=8'h8A; rxErr=0; rxBusy low afterwards.
- Send 8'b01111010 immediately followed by 8'hFF with zero idle bits → two rxDone pulses 10*16*DIV cycles apart; rxOut=8'h7A then 8'hFF.
- Low glitch of 3 bit-ticks on an idle line → rxBusy rises then falls at E+9*DIV+1; no rxDone or rxErr; rxOut unchanged.
- Frame 8'h55 with the stop bit low and the line held low for 2 bit times → rxErr pulse; rxOut keeps its prior value; rxBusy stays high until the line returns high; the next frame 8'hA5 is received correctly.
- Drop rxEn during data bit 4 of a frame, and assert rst mid-frame in a separate run → rxBusy 0 on the next cycle; no pulses; rst case returns every output to its reset value.
- With UART_RX_MAJORITY_EN defined, a one-tick low spike at tick 8 of a '1' data bit → the byte is still received correctly. Without the macro → that bit reads 0.

Source files
------------

// File: rtl/uart_rx8.sv
// 8N1 UART receiver: 16x oversampling, start-bit validation, framing-error detection.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote over ticks 7/8/9 instead of the tick-8 sample.
module uart_rx8 #(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut
);

  localparam int unsigned DIV   = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateT;

  stateT            state;
  stateT            stateNext;
  logic             syncA;
  logic             line;
  logic [PRE_W-1:0] preCnt;
  logic [3:0]       tickCnt;
  logic [3:0]       tickNext;
  logic             tick;
  logic             decide;
  logic             timerClr;
  logic             sample8;
  logic             bitVal;
  logic             shiftEn;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic [7:0]       rxOutReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      syncA <= 1'b1;
      line  <= 1'b1;
    end else begin
      syncA <= rxIn;
      line  <= syncA;
    end
  end

  // Held cleared while IDLE, so the start-edge cycle leaves both counters at zero.
  assign timerClr = !rxEn || (state == IDLE);
  assign tick     = (preCnt == PRE_LAST);
  assign tickNext = tickCnt + 4'd1;
  assign decide   = tick && (tickNext == 4'd9);

  always_ff @(posedge clk) begin
    if (rst || timerClr) begin
      preCnt  <= '0;
      tickCnt <= '0;
    end else if (tick) begin
      preCnt  <= '0;
      tickCnt <= tickNext;
    end else begin
      preCnt  <= preCnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample8 <= 1'b1;
    end else if (tick && (tickNext == 4'd8)) begin
      sample8 <= line;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic sample7;

  always_ff @(posedge clk) begin
    if (rst) begin
      sample7 <= 1'b1;
    end else if (tick && (tickNext == 4'd7)) begin
      sample7 <= line;
    end
  end

  // The tick-9 sample is the live line value in the decision cycle.
  assign bitVal = (sample7 & sample8) | (sample7 & line) | (sample8 & line);
`else
  assign bitVal = sample8;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    rxDone    = 1'b0;
    rxErr     = 1'b0;
    shiftEn   = 1'b0;
    if (rst || !rxEn) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!line) stateNext = START;
        end
        START: begin
          if (decide) stateNext = bitVal ? IDLE : DATA;
        end
        DATA: begin
          if (decide) begin
            shiftEn = 1'b1;
            if (bitIdx == 3'd7) stateNext = STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (bitVal) begin
              rxDone    = 1'b1;
              stateNext = IDLE;
            end else begin
              rxErr     = 1'b1;
              stateNext = BREAK;
            end
          end
        end
        BREAK: begin
          if (line) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitIdx   <= '0;
      shiftReg <= '0;
      rxOutReg <= '0;
    end else begin
      if (state == START) begin
        bitIdx <= '0;
      end else if (shiftEn) begin
        bitIdx <= bitIdx + 3'd1;
      end
      if (shiftEn) shiftReg <= {bitVal, shiftReg[7:1]};
      if (rxDone) rxOutReg <= shiftReg;
    end
  end

  // Bypass the holding register in the rxDone cycle so the new byte appears with the pulse.
  assign rxOut  = rxDone ? shiftReg : rxOutReg;
  assign rxBusy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx8.sv
// Self-checking bench for uart_rx8: table of whole frames plus hand-written corner sequences.
// Runs at 9600 baud from a 1 MHz clock (DIV = 6) to keep frames short.
module tb_uart_rx8;

  localparam int DIV       = 1000000 / (9600 * 16);
  localparam int BITC      = 16 * DIV;
  localparam int SYNC_LAT  = 2;
  localparam int PULSE_LAT = 153 * DIV;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         expDone;
    int         expErr;
    logic [7:0] expOut;
  } vecT;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxEn;
  logic       rxIn;
  logic       rxBusy;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxOut;

  uart_rx8 #(
    .CLOCK_RATE(1000000),
    .BAUD_RATE (9600),
    .OVERSAMPLE(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rxEn  (rxEn),
    .rxIn  (rxIn),
    .rxBusy(rxBusy),
    .rxDone(rxDone),
    .rxErr (rxErr),
    .rxOut (rxOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         doneCnt  = 0;
  int         errCnt   = 0;
  int         bothCnt  = 0;
  int         doneCyc  = -1;
  int         errCyc   = -1;
  int         busyRise = -1;
  int         busyFall = -1;
  logic [7:0] doneVal  = '0;
  logic       prevBusy = 1'b0;

  always @(negedge clk) begin
    if (rxDone === 1'b1) begin
      doneCnt <= doneCnt + 1;
      doneCyc <= cyc;
      doneVal <= rxOut;
    end
    if (rxErr === 1'b1) begin
      errCnt <= errCnt + 1;
      errCyc <= cyc;
    end
    if ((rxDone === 1'b1) && (rxErr === 1'b1)) bothCnt <= bothCnt + 1;
    if ((rxBusy === 1'b1) && (prevBusy === 1'b0)) busyRise <= cyc;
    if ((rxBusy === 1'b0) && (prevBusy === 1'b1)) busyFall <= cyc;
    prevBusy <= rxBusy;
  end

  int total  = 0;
  int passed = 0;
  int t0     = 0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
  endtask

  task automatic tickCyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic driveBit(input logic b, input int n);
    rxIn = b;
    tickCyc(n);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    t0 = cyc;
    driveBit(1'b0, BITC);
    for (int unsigned k = 0; k < 8; k++) driveBit(d[k], BITC);
    driveBit(stopBit, BITC);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: got no finish, expected finish within 200000 cycles");
    $fatal(1);
  end

  vecT        vecs[5];
  int         d0;
  int         e0;
  int         r;
  int         firstDone;
  logic [7:0] firstVal;
  logic [7:0] b;
  logic [7:0] spikeExp;

  initial begin
    vecs[0] = '{8'h8A, 1'b1, 1, 0, 8'h8A};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'h3C, 1'b0, 0, 1, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};

    rst  = 1'b1;
    rxEn = 1'b0;
    rxIn = 1'b1;
    tickCyc(4);
    chk("reset rxBusy", rxBusy, 0);
    chk("reset rxDone", rxDone, 0);
    chk("reset rxErr", rxErr, 0);
    chk("reset rxOut", rxOut, 8'h00);
    rst  = 1'b0;
    rxEn = 1'b1;
    tickCyc(BITC);
    chk("idle rxBusy", rxBusy, 0);

    for (int i = 0; i < 5; i++) begin
      d0 = doneCnt;
      e0 = errCnt;
      sendFrame(vecs[i].data, vecs[i].stopBit);
      rxIn = 1'b1;
      r = cyc;
      tickCyc(2 * BITC);
      chk($sformatf("vec%0d done count", i), doneCnt - d0, vecs[i].expDone);
      chk($sformatf("vec%0d err count", i), errCnt - e0, vecs[i].expErr);
      chk($sformatf("vec%0d busy rise", i), busyRise, t0 + SYNC_LAT + 1);
      if (vecs[i].expDone == 1) begin
        chk($sformatf("vec%0d done cycle", i), doneCyc, t0 + SYNC_LAT + PULSE_LAT);
        chk($sformatf("vec%0d rxOut at pulse", i), doneVal, vecs[i].expOut);
        chk($sformatf("vec%0d busy fall", i), busyFall, t0 + SYNC_LAT + PULSE_LAT + 1);
      end else begin
        chk($sformatf("vec%0d err cycle", i), errCyc, t0 + SYNC_LAT + PULSE_LAT);
        chk($sformatf("vec%0d busy fall", i), busyFall, r + 3);
      end
      chk($sformatf("vec%0d rxOut", i), rxOut, vecs[i].expOut);
      chk($sformatf("vec%0d rxBusy idle", i), rxBusy, 0);
    end

    // Back-to-back frames with zero idle bits.
    d0 = doneCnt;
    sendFrame(8'h7A, 1'b1);
    firstDone = doneCyc;
    firstVal  = doneVal;
    chk("b2b first cycle", firstDone, t0 + SYNC_LAT + PULSE_LAT);
    sendFrame(8'hFF, 1'b1);
    tickCyc(BITC);
    chk("b2b done count", doneCnt - d0, 2);
    chk("b2b first byte", firstVal, 8'h7A);
    chk("b2b second byte", doneVal, 8'hFF);
    chk("b2b spacing", doneCyc - firstDone, 160 * DIV);
    chk("b2b rxOut", rxOut, 8'hFF);

    // Framing error with the line held low afterwards, then recovery.
    d0 = doneCnt;
    e0 = errCnt;
    sendFrame(8'h55, 1'b0);
    driveBit(1'b0, 2 * BITC);
    chk("brk err count", errCnt - e0, 1);
    chk("brk err cycle", errCyc, t0 + SYNC_LAT + PULSE_LAT);
    chk("brk no done", doneCnt - d0, 0);
    chk("brk rxOut kept", rxOut, 8'hFF);
    chk("brk busy held", rxBusy, 1);
    r = cyc;
    driveBit(1'b1, BITC);
    chk("brk busy fall", busyFall, r + 3);
    sendFrame(8'hA5, 1'b1);
    tickCyc(BITC);
    chk("brk next done count", doneCnt - d0, 1);
    chk("brk next byte", doneVal, 8'hA5);
    chk("brk next err count", errCnt - e0, 1);

    // Three-tick glitch: false start.
    d0 = doneCnt;
    e0 = errCnt;
    t0 = cyc;
    driveBit(1'b0, 3 * DIV);
    driveBit(1'b1, 2 * BITC);
    chk("glitch busy rise", busyRise, t0 + SYNC_LAT + 1);
    chk("glitch busy fall", busyFall, t0 + SYNC_LAT + 9 * DIV + 1);
    chk("glitch no done", doneCnt - d0, 0);
    chk("glitch no err", errCnt - e0, 0);
    chk("glitch rxOut", rxOut, 8'hA5);

    // rxEn dropped in the middle of data bit 4.
    d0 = doneCnt;
    e0 = errCnt;
    b = 8'h33;
    t0 = cyc;
    driveBit(1'b0, BITC);
    for (int unsigned k = 0; k < 4; k++) driveBit(b[k], BITC);
    driveBit(b[4], BITC / 2);
    chk("en busy before drop", rxBusy, 1);
    rxEn = 1'b0;
    r = cyc;
    tickCyc(1);
    chk("en busy fall", busyFall, r + 1);
    chk("en rxBusy low", rxBusy, 0);
    tickCyc(BITC / 2 - 1);
    for (int unsigned k = 5; k < 8; k++) driveBit(b[k], BITC);
    driveBit(1'b1, 2 * BITC);
    rxEn = 1'b1;
    tickCyc(BITC);
    chk("en no done", doneCnt - d0, 0);
    chk("en no err", errCnt - e0, 0);
    chk("en rxOut", rxOut, 8'hA5);

    // One-tick low spike centred on the tick-8 sample of data bit 3 (a '1').
`ifdef UART_RX_MAJORITY_EN
    spikeExp = 8'hFF;
`else
    spikeExp = 8'hF7;
`endif
    d0 = doneCnt;
    t0 = cyc;
    driveBit(1'b0, BITC);
    for (int unsigned k = 0; k < 8; k++) begin
      if (k == 3) begin
        driveBit(1'b1, 8 * DIV - 3);
        driveBit(1'b0, DIV);
        driveBit(1'b1, 7 * DIV + 3);
      end else begin
        driveBit(1'b1, BITC);
      end
    end
    driveBit(1'b1, 2 * BITC);
    chk("spike done count", doneCnt - d0, 1);
    chk("spike done cycle", doneCyc, t0 + SYNC_LAT + PULSE_LAT);
    chk("spike byte", doneVal, spikeExp);

    // Synchronous reset in the middle of data bit 2.
    d0 = doneCnt;
    e0 = errCnt;
    b = 8'h5A;
    driveBit(1'b0, BITC);
    for (int unsigned k = 0; k < 2; k++) driveBit(b[k], BITC);
    driveBit(b[2], BITC / 2);
    rst = 1'b1;
    r = cyc;
    tickCyc(1);
    chk("rst busy fall", busyFall, r + 1);
    chk("rst rxBusy", rxBusy, 0);
    chk("rst rxDone", rxDone, 0);
    chk("rst rxErr", rxErr, 0);
    chk("rst rxOut", rxOut, 8'h00);
    driveBit(1'b1, BITC);
    rst = 1'b0;
    tickCyc(2 * BITC);
    chk("rst no done", doneCnt - d0, 0);
    chk("rst no err", errCnt - e0, 0);
    chk("rst rxOut after", rxOut, 8'h00);
    chk("rst rxBusy after", rxBusy, 0);

    chk("done/err exclusive", bothCnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
